// File: rtl/tick_gen_pkg.sv
// Shared constants for the tick prescaler: FSM encoding, mode encoding, defaults.
// Burst helper is compiled only with TICK_GEN_BURST_EN.
package tick_gen_pkg;

  localparam int DIV_W_DEF       = 8;
  localparam int DIV_DEFAULT_DEF = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

`ifdef TICK_GEN_BURST_EN
  // True when the tick being emitted now is the last one of a bounded burst.
  function automatic logic burst_last(input logic [7:0] sent, input logic [7:0] len);
    return (len != 8'd0) && (sent == (len - 8'd1));
  endfunction
`endif

endpackage

// File: rtl/tick_gen_if.sv
// Control/status bundle between the tick prescaler and its enclosing level.
// Burst signals exist only with TICK_GEN_BURST_EN.
interface tick_gen_if #(parameter int DIV_W = tick_gen_pkg::DIV_W_DEF);

  logic             start;
  logic             stop;
  logic             mode;
  logic             div_ld;
  logic [DIV_W-1:0] div_in;
  logic             tick;
  logic             busy;
  logic [DIV_W-1:0] div_q;
`ifdef TICK_GEN_BURST_EN
  logic [7:0]       burst_len;
  logic             done;

  modport master (output start, stop, mode, div_ld, div_in, burst_len,
                  input  tick, busy, div_q, done);
  modport slave  (input  start, stop, mode, div_ld, div_in, burst_len,
                  output tick, busy, div_q, done);
`else
  modport master (output start, stop, mode, div_ld, div_in,
                  input  tick, busy, div_q);
  modport slave  (input  start, stop, mode, div_ld, div_in,
                  output tick, busy, div_q);
`endif

endinterface

// File: rtl/tick_gen_dcnt.sv
// Loadable down-counter that saturates at zero; load has priority over enable.
module tick_gen_dcnt #(
  parameter int DIV_W = 8
) (
  input  logic             ck,
  input  logic             res,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] load_val,
  output logic             zero
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Next count: load, decrement toward zero, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != {DIV_W{1'b0}})) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      cnt_q <= {DIV_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {DIV_W{1'b0}});

endmodule

// File: rtl/tick_gen.sv
// Programmable tick prescaler: one-cycle tick every div_q+1 cycles, continuous or single-shot.
// Optional bounded bursts with a done pulse when TICK_GEN_BURST_EN is defined.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
  input  logic       ck,
  input  logic       res,
  tick_gen_if.slave  bus
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);

  logic [0:0]       state_q, state_d;
  logic             mode_l_q, mode_l_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] div_reg_q, div_reg_d;
  logic             cnt_load_s, cnt_en_s, cnt_zero_s;
  logic [DIV_W-1:0] cnt_val_s;
`ifdef TICK_GEN_BURST_EN
  logic [7:0]       burst_len_q, burst_len_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic             done_q, done_d;
`endif

  tick_gen_dcnt #(.DIV_W(DIV_W)) u_dcnt (
    .ck       (ck),
    .res      (res),
    .load     (cnt_load_s),
    .en       (cnt_en_s),
    .load_val (cnt_val_s),
    .zero     (cnt_zero_s)
  );

  // FSM next state, divisor write and counter control; stop outranks a due tick.
  always_comb begin
    state_d    = state_q;
    mode_l_d   = mode_l_q;
    tick_d     = 1'b0;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    cnt_val_s  = div_reg_q;
`ifdef TICK_GEN_BURST_EN
    burst_len_d = burst_len_q;
    burst_cnt_d = burst_cnt_q;
    done_d      = 1'b0;
`endif
    if (bus.div_ld) begin
      div_reg_d = bus.div_in;
    end else begin
      div_reg_d = div_reg_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d    = ST_RUN;
          mode_l_d   = bus.mode;
          cnt_load_s = 1'b1;
`ifdef TICK_GEN_BURST_EN
          burst_len_d = bus.burst_len;
          burst_cnt_d = 8'd0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d    = ST_IDLE;
          cnt_load_s = 1'b1;
          cnt_val_s  = {DIV_W{1'b0}};
        end else if (cnt_zero_s) begin
          // Reload reads the pre-edge divisor, so a same-edge div_ld lands next period.
          tick_d     = 1'b1;
          cnt_load_s = 1'b1;
          if (mode_l_q == MODE_SINGLE) begin
            state_d   = ST_IDLE;
            cnt_val_s = {DIV_W{1'b0}};
`ifdef TICK_GEN_BURST_EN
            done_d    = 1'b1;
          end else if (burst_last(burst_cnt_q, burst_len_q)) begin
            state_d   = ST_IDLE;
            cnt_val_s = {DIV_W{1'b0}};
            done_d    = 1'b1;
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
`else
          end else begin
            state_d = ST_RUN;
`endif
          end
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, mode latch, tick and divisor registers.
  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      state_q   <= ST_IDLE;
      mode_l_q  <= MODE_CONT;
      tick_q    <= 1'b0;
      div_reg_q <= DIV_RST;
`ifdef TICK_GEN_BURST_EN
      burst_len_q <= 8'd0;
      burst_cnt_q <= 8'd0;
      done_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mode_l_q  <= mode_l_d;
      tick_q    <= tick_d;
      div_reg_q <= div_reg_d;
`ifdef TICK_GEN_BURST_EN
      burst_len_q <= burst_len_d;
      burst_cnt_q <= burst_cnt_d;
      done_q      <= done_d;
`endif
    end
  end

  assign bus.tick  = tick_q;
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.div_q = div_reg_q;
`ifdef TICK_GEN_BURST_EN
  assign bus.done  = done_q;
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Directed self-checking bench for tick_gen; burst scenario compiled with TICK_GEN_BURST_EN.
module tb_tick_gen;

  logic ck;
  logic res;
  int   checks;
  int   errors;

  tick_gen_if #(.DIV_W(8)) bus ();

  tick_gen #(.DIV_W(8), .DIV_DEFAULT(4)) dut (
    .ck  (ck),
    .res (res),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Advance one rising edge and settle just after it.
  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic load_div(input logic [7:0] v);
    bus.div_ld = 1'b1;
    bus.div_in = v;
    cyc();
    bus.div_ld = 1'b0;
  endtask

  task automatic start_run(input logic m);
    bus.start = 1'b1;
    bus.mode  = m;
    cyc();
    bus.start = 1'b0;
    bus.mode  = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    cyc();
    cyc();
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL rst_tick got=%b exp=0", bus.tick); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.div_q !== 8'd4) begin errors++; $display("FAIL rst_div got=%0d exp=4", bus.div_q); end
    bus.start = 1'b0;
    res = 1'b0;
    cyc();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rel_busy got=%b exp=0", bus.busy); end
    for (int k = 1; k <= 20; k++) begin
      cyc();
      checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL idle_tick k=%0d got=%b exp=0", k, bus.tick); end
    end
  endtask

  task automatic test_continuous();
    logic [1:0] ct2;
    logic [1:0] ct_exp [4];
    int         nt;
    ct_exp = '{2'b01, 2'b10, 2'b11, 2'b00};
    ct2 = 2'b00;
    nt  = 0;
    start_run(1'b0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL cont_busy got=%b exp=1", bus.busy); end
    for (int k = 1; k <= 20; k++) begin
      cyc();
      checks++; if (bus.tick !== ((k % 5) == 0)) begin errors++; $display("FAIL cont_tick k=%0d got=%b", k, bus.tick); end
      if (bus.tick === 1'b1 && nt < 4) begin
        ct2 = ct2 + 2'd1;
        checks++; if (ct2 !== ct_exp[nt]) begin errors++; $display("FAIL ct2bit got=%b exp=%b", ct2, ct_exp[nt]); end
        nt++;
      end
    end
    checks++; if (nt !== 4) begin errors++; $display("FAIL cont_count got=%0d exp=4", nt); end
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cont_stop got=%b exp=0", bus.busy); end
  endtask

  task automatic test_single_shot();
    load_div(8'd2);
    checks++; if (bus.div_q !== 8'd2) begin errors++; $display("FAIL ss_div got=%0d exp=2", bus.div_q); end
    start_run(1'b1);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ss_busy0 got=%b exp=1", bus.busy); end
    for (int k = 1; k <= 13; k++) begin
      cyc();
      checks++; if (bus.tick !== (k == 3)) begin errors++; $display("FAIL ss_tick k=%0d got=%b", k, bus.tick); end
      checks++; if (bus.busy !== (k < 3)) begin errors++; $display("FAIL ss_busy k=%0d got=%b", k, bus.busy); end
    end
  endtask

  task automatic test_stop_collision();
    start_run(1'b0);
    cyc();
    cyc();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL stop_tick got=%b exp=0", bus.tick); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b exp=0", bus.busy); end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL stop_after k=%0d got=%b", k, bus.tick); end
    end
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL coll_busy got=%b exp=0", bus.busy); end
    for (int k = 1; k <= 5; k++) begin
      cyc();
      checks++; if (bus.tick !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL coll_idle k=%0d tick=%b busy=%b", k, bus.tick, bus.busy); end
    end
  endtask

  task automatic test_div_change();
    load_div(8'd4);
    start_run(1'b0);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      checks++; if (bus.tick !== (k inside {5, 7, 9, 11, 13, 15, 19})) begin errors++; $display("FAIL chg_tick k=%0d got=%b", k, bus.tick); end
      if (k == 3) begin
        checks++; if (bus.div_q !== 8'd1) begin errors++; $display("FAIL chg_div got=%0d exp=1", bus.div_q); end
      end
      bus.div_ld = (k == 2) || (k == 12);
      bus.div_in = (k == 2) ? 8'd1 : 8'd3;
    end
    bus.div_ld = 1'b0;
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
  endtask

  task automatic test_div_extremes();
    load_div(8'd255);
    start_run(1'b0);
    for (int k = 1; k <= 520; k++) begin
      cyc();
      checks++; if (bus.tick !== (k == 256 || k == 512)) begin errors++; $display("FAIL max_tick k=%0d got=%b", k, bus.tick); end
    end
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    load_div(8'd0);
    start_run(1'b0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL zero_tick k=%0d got=%b exp=1", k, bus.tick); end
    end
    // Reset lands while tick is high: outputs must clear without an edge.
    res = 1'b1;
    #1;
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL async_tick got=%b exp=0", bus.tick); end
    checks++; if (bus.div_q !== 8'd4) begin errors++; $display("FAIL async_div got=%0d exp=4", bus.div_q); end
    cyc();
    res = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_run();
    load_div(8'd6);
    start_run(1'b0);
    cyc();
    cyc();
    cyc();
    res = 1'b1;
    #1;
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL mid_tick got=%b exp=0", bus.tick); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.div_q !== 8'd4) begin errors++; $display("FAIL mid_div got=%0d exp=4", bus.div_q); end
    cyc();
    res = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL mid_after k=%0d got=%b", k, bus.tick); end
    end
  endtask

`ifdef TICK_GEN_BURST_EN
  task automatic test_burst();
    bus.burst_len = 8'd3;
    start_run(1'b0);
    bus.burst_len = 8'd0;
    for (int k = 1; k <= 25; k++) begin
      cyc();
      checks++; if (bus.tick !== (k inside {5, 10, 15})) begin errors++; $display("FAIL burst_tick k=%0d got=%b", k, bus.tick); end
      checks++; if (bus.done !== (k == 15)) begin errors++; $display("FAIL burst_done k=%0d got=%b", k, bus.done); end
      checks++; if (bus.busy !== (k < 15)) begin errors++; $display("FAIL burst_busy k=%0d got=%b", k, bus.busy); end
    end
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    res        = 1'b1;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.mode   = 1'b0;
    bus.div_ld = 1'b0;
    bus.div_in = 8'd0;
`ifdef TICK_GEN_BURST_EN
    bus.burst_len = 8'd0;
`endif
    test_reset();
    test_continuous();
    test_single_shot();
    test_stop_collision();
    test_div_change();
    test_div_extremes();
    test_reset_mid_run();
`ifdef TICK_GEN_BURST_EN
    test_burst();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
Name: tick_gen

Overview:
- Programmable tick prescaler sitting directly upstream of the 2-bit counter stage (ct2bit).
- Generates single-cycle `tick` enables at a programmable period; the counter advances only on `tick`.
- Supports continuous and single-shot operation with start/stop control.
- `busy` and divisor status are available for the enclosing test/top level.

Parameters:
- DIV_W, 8, width of divisor register and internal down-counter.
- DIV_DEFAULT, 4, divisor value loaded at reset; tick period = divisor+1 cycles.

Ports:
- ck  input  1  system clock, all state on rising edge.
- res  input  1  reset; asynchronous and active-high.
- start  input  1  begin tick generation; sampled only in IDLE.
- stop  input  1  abort tick generation; highest priority.
- mode  input  1  0 = continuous, 1 = single-shot; latched on accepted start.
- div_ld  input  1  load div_in into the divisor register this cycle.
- div_in  input  DIV_W  new divisor value.
- tick  output  1  registered one-cycle enable pulse to the downstream counter.
- busy  output  1  high whenever FSM is not IDLE.
- div_q  output  DIV_W  current divisor register contents.

Behaviour:
- Reset (res=1, any time, including mid-count):
  - state=IDLE, tick=0, busy=0, cnt=0, mode_l=0, div_q=DIV_DEFAULT.
  - Effect is immediate; no pulse is emitted while res is high.
- Divisor register:
  - div_ld=1 writes div_in to div_q at the next edge, in any state.
  - In RUN, the new value takes effect only at the next reload; the countdown in flight is unaffected.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 and stop=0 -> RUN; cnt<=div_q; mode_l<=mode.
  - start and stop both high -> remain IDLE.
  - tick=0.
- RUN:
  - stop=1 -> IDLE; tick=0 that cycle (a pulse due that cycle is suppressed); cnt cleared.
  - Else if cnt==0:
    - tick<=1 for exactly one cycle; cnt<=div_q (reloaded, picking up any pending div_ld value).
    - If mode_l=1, -> IDLE in the same edge.
  - Else cnt<=cnt-1, tick<=0.
  - start is ignored in RUN.
- Latency:
  - First tick is high during the cycle following the (div_q+1)-th rising edge after the edge that accepted start.
  - Subsequent ticks follow every div_q+1 cycles.
- div_q=0 gives a tick on every cycle in continuous mode.
- div_q at its maximum value (all ones, 255 for DIV_W=8) gives period 2^DIV_W; the counter wraps only via reload and never decrements below 0.
- busy=1 from the edge after start is accepted until the edge that returns to IDLE.
  - In single-shot mode, busy falls on the same edge that raises tick.
- Simultaneous div_ld with a reload edge: the reload uses the old div_q; the new value applies to the following period.

Optional Feature:
- Macro: TICK_GEN_BURST_EN.
- Defined:
  - Adds input burst_len[7:0] (latched on accepted start) and output done (1 cycle, reset 0).
  - In continuous mode with latched burst_len≠0, FSM returns to IDLE after emitting burst_len ticks.
  - done pulses coincident with the final tick.
  - stop still aborts the burst with no done pulse.
  - burst_len=0 means unlimited.
  - done also pulses with the single-shot tick.
- Undefined:
  - No burst_len or done ports.
  - Continuous mode runs until stop.

Decomposition:
- Shared package/header tick_gen_pkg:
  - State encoding constants (IDLE=0, RUN=1).
  - DIV_W and DIV_DEFAULT defaults.
  - Mode encoding (MODE_CONT=0, MODE_SINGLE=1).
- One natural sub-module: tick_gen_dcnt, a loadable DIV_W down-counter.
  - Inputs: ck, res, load, en, load_val.
  - Output: zero flag.
- The FSM, divisor register and tick register remain in tick_gen.

Test Plan:
- Reset then idle: res=1 for 2 cycles, release -> tick=0, busy=0, div_q=4. Hold start=0 for 20 cycles -> no tick.
- Continuous default: start=1, mode=0 for one cycle -> tick pulses every 5 cycles; 4 pulses in 20 cycles; driven ct2bit output goes 00->01->10->11->00.
- Single-shot with div_in=2: div_ld, then start with mode=1 -> exactly one tick 3 cycles after start; busy drops the same edge; no further ticks in 10 cycles.
- Stop and collision:
  - stop asserted on the cycle a tick is due -> no tick, busy=0 next cycle.
  - start and stop together in IDLE -> stays IDLE.
- Divisor change mid-run: running with div=4, load div=1 at cnt=2 -> current period completes at 5 cycles, following periods are 2 cycles.
- Reset mid-operation and burst:
  - res pulsed while RUN with cnt=3 -> tick=0, busy=0, div_q=4 immediately.
  - With TICK_GEN_BURST_EN, burst_len=3 -> exactly 3 ticks, done on the third.
